mem_access_unit: RTL

Parametrised, handshaked memory-stage access unit for the pipelined CPU. It accepts one load/store request at a time, aligns it onto a word-wide data-memory port with byte enables, and waits a variable number of cycles for memory acknowledge. It sign- or zero-extends load data and reports a classified halt on a misaligned address, an illegal funct3, a memory timeout or an incoming halt. It replaces the single-cycle combinational memory stage and latches a sticky halted state.

---
 rtl/mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked load/store unit for the pipeline memory stage.
// Accepts one request at a time, drives a word-wide data-memory port with
// lane-aligned byte enables and store data, and waits up to MAX_WAIT cycles
// for mem_ack. Load data is shifted down and sign/zero-extended. Misaligned
// addresses, illegal funct3, timeouts and upstream halts end in a sticky
// HALTED state that only rst leaves.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_is_load/is_store     opcode decode
//   req_funct3, req_addr     access size/sign and effective address
//   req_wdata, req_halt_in   store data, upstream halt
//   mem_req/we/addr/be/wdata data-memory request (registered)
//   mem_ack, mem_rdata       memory completion and read word
//   rsp_valid/rdata/halt/cause  one-cycle response
module mem_access_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_halt_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_halt,
    output logic [1:0]        rsp_cause
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned CW = 8;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISAL   = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HALTED} state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [NB-1:0]   r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;
    logic [OW-1:0]   r_off;
    logic [2:0]      r_funct3;
    logic            r_is_load;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_halt;
    logic [1:0]      r_rsp_cause;

    logic [OW-1:0]   w_off;
    logic [2:0]      w_off3;
    logic            w_mem_op;
    logic            w_illegal;
    logic            w_misaligned;
    logic [NB-1:0]   w_size_mask;
    logic [XLEN-1:0] w_rshift;
    logic [XLEN-1:0] w_load_ext;

    assign w_off    = req_addr[OW-1:0];
    assign w_off3   = 3'(w_off);
    assign w_mem_op = req_is_load | req_is_store;

    // funct3 legality; dword forms exist only on a 64-bit datapath
    always_comb begin
        w_illegal = 1'b0;
        if (req_is_load && req_is_store) begin
            w_illegal = 1'b1;
        end else if (req_is_load) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                3'b011, 3'b110:                         w_illegal = (XLEN != 64);
                default:                                w_illegal = 1'b1;
            endcase
        end else if (req_is_store) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
                3'b011:                 w_illegal = (XLEN != 64);
                default:                w_illegal = 1'b1;
            endcase
        end
    end

    // Alignment check and lane mask by access size
    always_comb begin
        w_misaligned = 1'b0;
        w_size_mask  = NB'(8'h01);
        case (req_funct3[1:0])
            2'b00: begin
                w_misaligned = 1'b0;
                w_size_mask  = NB'(8'h01);
            end
            2'b01: begin
                w_misaligned = w_off3[0];
                w_size_mask  = NB'(8'h03);
            end
            2'b10: begin
                w_misaligned = (w_off3[1:0] != 2'b00);
                w_size_mask  = NB'(8'h0F);
            end
            default: begin
                w_misaligned = (w_off3 != 3'b000);
                w_size_mask  = NB'(8'hFF);
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by size/sign
    assign w_rshift = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_rshift;
        case (r_funct3[1:0])
            2'b00: begin
                if (r_funct3[2]) w_load_ext = XLEN'(w_rshift[7:0]);
                else             w_load_ext = XLEN'($signed(w_rshift[7:0]));
            end
            2'b01: begin
                if (r_funct3[2]) w_load_ext = XLEN'(w_rshift[15:0]);
                else             w_load_ext = XLEN'($signed(w_rshift[15:0]));
            end
            2'b10: begin
                if (r_funct3[2]) w_load_ext = XLEN'(w_rshift[31:0]);
                else             w_load_ext = XLEN'($signed(w_rshift[31:0]));
            end
            default: w_load_ext = w_rshift;
        endcase
    end

    // Control FSM; every output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_is_load   <= 1'b0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_halt  <= 1'b0;
            r_rsp_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_off       <= w_off;
                        r_funct3    <= req_funct3;
                        r_is_load   <= req_is_load;
                        r_rsp_rdata <= '0;
                        if (req_halt_in || !w_mem_op || w_illegal || w_misaligned) begin
                            // no memory access: answer next cycle
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            if (req_halt_in) begin
                                r_rsp_halt  <= 1'b1;
                                r_rsp_cause <= CAUSE_NONE;
                            end else if (!w_mem_op) begin
                                r_rsp_halt  <= 1'b0;
                                r_rsp_cause <= CAUSE_NONE;
                            end else if (w_illegal) begin
                                r_rsp_halt  <= 1'b1;
                                r_rsp_cause <= CAUSE_ILLEGAL;
                            end else begin
                                r_rsp_halt  <= 1'b1;
                                r_rsp_cause <= CAUSE_MISAL;
                            end
                        end else begin
                            r_state     <= S_WAIT;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_is_store;
                            r_mem_addr  <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
                            r_mem_be    <= w_size_mask << w_off;
                            r_mem_wdata <= req_wdata << {w_off, 3'b000};
                            r_wait_cnt  <= CW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // ack wins over a timeout in the same cycle
                    if (mem_ack || (r_wait_cnt == CW'(MAX_WAIT))) begin
                        r_state     <= S_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                        r_rsp_valid <= 1'b1;
                        if (mem_ack) begin
                            r_rsp_rdata <= r_is_load ? w_load_ext : '0;
                            r_rsp_halt  <= 1'b0;
                            r_rsp_cause <= CAUSE_NONE;
                        end else begin
                            r_rsp_rdata <= '0;
                            r_rsp_halt  <= 1'b1;
                            r_rsp_cause <= CAUSE_TIMEOUT;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_halt  <= 1'b0;
                    r_rsp_cause <= CAUSE_NONE;
                    if (r_rsp_halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_halt  = r_rsp_halt;
    assign rsp_cause = r_rsp_cause;

endmodule
